nbody_sim_core: RTL and testbench

Parametrised N-body sprite simulator for the TinyVGA 320x240 logical display. Holds position/velocity state for `N_BODIES` square sprites, applies pairwise Manhattan-distance attraction once per frame, and draws the sprites combinationally from the pixel coordinates. Force evaluation is time-multiplexed, one body pair per clock, so adder count stays flat as `N_BODIES` grows. It sits between `hvsync_generator` and the `uo_out` PMOD mapping in the top level.

---
 rtl/nbody_sim_core_if.sv | 28 ++
 rtl/nbody_sim_core.sv | 254 +++++++++++++++++++++++++
 tb/tb_nbody_sim_core.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nbody_sim_core_if.sv
`default_nettype none
// ============================================================================
// Module   : nbody_sim_core_if
// Brief    : Frame-control and pixel-query bundle between the video top level
//            and the N-body sprite core.
// Revision : 1.0 - initial release
// ============================================================================
interface nbody_sim_core_if;
    logic       frame_tick;
    logic       pause;
    logic       video_active;
    logic [8:0] pix_x320;
    logic [7:0] pix_y240;
    logic [5:0] rgb;
    logic [2:0] hit_id;
    logic       busy;

    modport master (
        output frame_tick, pause, video_active, pix_x320, pix_y240,
        input  rgb, hit_id, busy
    );

    modport slave (
        input  frame_tick, pause, video_active, pix_x320, pix_y240,
        output rgb, hit_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/nbody_sim_core.sv
`default_nettype none
// ============================================================================
// Module   : nbody_sim_core
// Brief    : N-body sprite simulator; one body pair per clock of force
//            evaluation, then one body per clock of integration.
// Revision : 1.0 - initial release
// ============================================================================
module nbody_sim_core #(
    parameter int N_BODIES = 3,
    parameter int RAD      = 8,
    parameter int VW       = 6,
    parameter int BOUNCE   = 0,
    parameter int NEAR_TH  = 20,
    parameter int FAR_TH   = 120
) (
    input wire              clk,
    input wire              rst_n,
    nbody_sim_core_if.slave bus
);

    localparam int IW = $clog2(N_BODIES);
    localparam int SW = ((VW > 5) ? VW : 5) + 1;
    localparam int PW = VW + 10;
    localparam int VMAX = 2 ** (VW - 1) - 1;
    localparam logic signed [SW-1:0] C_VMAX = SW'(VMAX);
    localparam logic signed [SW-1:0] C_VMIN = -C_VMAX;
    localparam logic [IW-1:0] C_LAST   = IW'(N_BODIES - 1);
    localparam logic [IW-1:0] C_LAST_I = IW'(N_BODIES - 2);
    localparam logic [2:0]    C_NO_HIT = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PAIR  = 2'd1,
        S_INTEG = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_start;
    logic   w_pair_last;

    logic [8:0]           r_x  [N_BODIES];
    logic [7:0]           r_y  [N_BODIES];
    logic signed [VW-1:0] r_vx [N_BODIES];
    logic signed [VW-1:0] r_vy [N_BODIES];
    logic signed [4:0]    r_ax [N_BODIES];
    logic signed [4:0]    r_ay [N_BODIES];
    logic [IW-1:0]        r_i, r_j, r_k;

    function automatic logic signed [VW-1:0] sat_v(input logic signed [SW-1:0] s);
        if (s > C_VMAX) return C_VMAX[VW-1:0];
        if (s < C_VMIN) return C_VMIN[VW-1:0];
        return s[VW-1:0];
    endfunction

    // ---------------- control ----------------
    assign w_pair_last = (r_i == C_LAST_I) && (r_j == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.frame_tick && !bus.pause) begin
                    w_state_nxt = S_PAIR;
                    w_start     = 1'b1;
                end
            end
            S_PAIR:  if (w_pair_last) w_state_nxt = S_INTEG;
            S_INTEG: if (r_k == C_LAST) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- pair force ----------------
    logic signed [9:0] w_dx;
    logic signed [8:0] w_dy;
    logic [9:0]        w_adx, w_dist;
    logic [8:0]        w_ady;
    logic [1:0]        w_mag;
    logic signed [4:0] w_m5, w_fx, w_fy;

    assign w_dx   = $signed({1'b0, r_x[r_j]}) - $signed({1'b0, r_x[r_i]});
    assign w_dy   = $signed({1'b0, r_y[r_j]}) - $signed({1'b0, r_y[r_i]});
    assign w_adx  = (w_dx < 0) ? 10'(-w_dx) : 10'(w_dx);
    assign w_ady  = (w_dy < 0) ? 9'(-w_dy) : 9'(w_dy);
    assign w_dist = w_adx + 10'(w_ady);
    assign w_mag  = (w_dist < 10'(NEAR_TH)) ? 2'd2 :
                    (w_dist < 10'(FAR_TH))  ? 2'd1 : 2'd0;
    assign w_m5   = $signed({3'b000, w_mag});
    assign w_fx   = (w_dx < 0) ? -w_m5 : w_m5;
    assign w_fy   = (w_dy < 0) ? -w_m5 : w_m5;

    // ---------------- integration of body r_k ----------------
    logic signed [SW-1:0] w_vx_sum, w_vy_sum;
    logic signed [VW-1:0] w_vx_sat, w_vy_sat, w_vx_new, w_vy_new;
    logic signed [PW-1:0] w_px_raw, w_py_raw;
    logic [8:0]           w_x_new;
    logic [7:0]           w_y_new;

    assign w_vx_sum = SW'(r_vx[r_k]) + SW'(r_ax[r_k]);
    assign w_vy_sum = SW'(r_vy[r_k]) + SW'(r_ay[r_k]);
    assign w_vx_sat = sat_v(w_vx_sum);
    assign w_vy_sat = sat_v(w_vy_sum);
    // Semi-implicit Euler: position advances with the freshly saturated velocity.
    assign w_px_raw = PW'($signed({1'b0, r_x[r_k]})) + PW'(w_vx_sat);
    assign w_py_raw = PW'($signed({1'b0, r_y[r_k]})) + PW'(w_vy_sat);

    always_comb begin
        w_x_new  = w_px_raw[8:0];
        w_vx_new = w_vx_sat;
        if (w_px_raw < 0) begin
            if (BOUNCE != 0) begin
                w_x_new  = 9'd0;
                w_vx_new = -w_vx_sat;
            end else begin
                w_x_new = 9'(w_px_raw + PW'(320));
            end
        end else if (w_px_raw > PW'(319)) begin
            if (BOUNCE != 0) begin
                w_x_new  = 9'd319;
                w_vx_new = -w_vx_sat;
            end else begin
                w_x_new = 9'(w_px_raw - PW'(320));
            end
        end
    end

    always_comb begin
        w_y_new  = w_py_raw[7:0];
        w_vy_new = w_vy_sat;
        if (w_py_raw < 0) begin
            if (BOUNCE != 0) begin
                w_y_new  = 8'd0;
                w_vy_new = -w_vy_sat;
            end else begin
                w_y_new = 8'(w_py_raw + PW'(240));
            end
        end else if (w_py_raw > PW'(239)) begin
            if (BOUNCE != 0) begin
                w_y_new  = 8'd239;
                w_vy_new = -w_vy_sat;
            end else begin
                w_y_new = 8'(w_py_raw - PW'(240));
            end
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i <= '0;
            r_j <= IW'(1);
            r_k <= '0;
            for (int b = 0; b < N_BODIES; b++) begin
                r_x[b]  <= 9'(24 + 48 * b);
                r_y[b]  <= 8'(20 + 36 * b);
                r_vx[b] <= '0;
                r_vy[b] <= '0;
                r_ax[b] <= '0;
                r_ay[b] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_i <= '0;
                        r_j <= IW'(1);
                        for (int b = 0; b < N_BODIES; b++) begin
                            r_ax[b] <= '0;
                            r_ay[b] <= '0;
                        end
                    end
                end
                S_PAIR: begin
                    for (int b = 0; b < N_BODIES; b++) begin
                        if (IW'(b) == r_i) begin
                            r_ax[b] <= r_ax[b] + w_fx;
                            r_ay[b] <= r_ay[b] + w_fy;
                        end else if (IW'(b) == r_j) begin
                            r_ax[b] <= r_ax[b] - w_fx;
                            r_ay[b] <= r_ay[b] - w_fy;
                        end
                    end
                    if (r_j == C_LAST) begin
                        r_i <= r_i + IW'(1);
                        r_j <= r_i + IW'(2);
                    end else begin
                        r_j <= r_j + IW'(1);
                    end
                    if (w_pair_last) r_k <= '0;
                end
                S_INTEG: begin
                    for (int b = 0; b < N_BODIES; b++) begin
                        if (IW'(b) == r_k) begin
                            r_x[b]  <= w_x_new;
                            r_y[b]  <= w_y_new;
                            r_vx[b] <= w_vx_new;
                            r_vy[b] <= w_vy_new;
                        end
                    end
                    r_k <= r_k + IW'(1);
                end
                default: ;
            endcase
        end
    end

    // ---------------- sprite drawing ----------------
    logic [N_BODIES-1:0] w_hit;
    logic [2:0]          w_hit_id;
    logic [5:0]          w_color;

    generate
        for (genvar b = 0; b < N_BODIES; b++) begin : g_hit
            logic signed [9:0] w_hx;
            logic signed [8:0] w_hy;
            assign w_hx = $signed({1'b0, bus.pix_x320}) - $signed({1'b0, r_x[b]});
            assign w_hy = $signed({1'b0, bus.pix_y240}) - $signed({1'b0, r_y[b]});
            assign w_hit[b] = (w_hx >= -10'(RAD)) && (w_hx <= 10'(RAD)) &&
                              (w_hy >= -9'(RAD))  && (w_hy <= 9'(RAD));
        end
    endgenerate

    always_comb begin
        w_hit_id = C_NO_HIT;
        for (int b = N_BODIES - 1; b >= 0; b--) begin
            if (w_hit[b]) w_hit_id = 3'(b);
        end
    end

    always_comb begin
        case (w_hit_id)
            3'd0:    w_color = 6'b111001;
            3'd1:    w_color = 6'b101110;
            3'd2:    w_color = 6'b010111;
            3'd3:    w_color = 6'b111111;
            3'd4:    w_color = 6'b110011;
            3'd5:    w_color = 6'b001111;
            default: w_color = 6'b000000;
        endcase
    end

    assign bus.rgb    = bus.video_active ? w_color : 6'd0;
    assign bus.hit_id = w_hit_id;
    assign bus.busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_nbody_sim_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_nbody_sim_core
// Brief    : Randomised self-checking bench for nbody_sim_core (wrap and
//            bounce instances) against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nbody_sim_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick, pause, va;
    logic [8:0] px;
    logic [7:0] py;

    always #5 clk = ~clk;

    nbody_sim_core_if bus_a ();
    nbody_sim_core_if bus_b ();

    assign bus_a.frame_tick   = tick;
    assign bus_a.pause        = pause;
    assign bus_a.video_active = va;
    assign bus_a.pix_x320     = px;
    assign bus_a.pix_y240     = py;
    assign bus_b.frame_tick   = tick;
    assign bus_b.pause        = pause;
    assign bus_b.video_active = va;
    assign bus_b.pix_x320     = px;
    assign bus_b.pix_y240     = py;

    nbody_sim_core dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    nbody_sim_core #(
        .N_BODIES (4),
        .VW       (4),
        .BOUNCE   (1)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // Reference model: instance 0 = wrap/N3/VW6, instance 1 = bounce/N4/VW4
    int n_b[2]  = '{3, 4};
    int vw_b[2] = '{6, 4};
    int bnc[2]  = '{0, 1};
    int pal[6]  = '{57, 46, 23, 63, 51, 15};
    int mx[2][6], my[2][6], mvx[2][6], mvy[2][6];
    int busy_until[2];
    int edge_cnt;
    int errors, checks;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 6; k++) begin
                mx[s][k] = 24 + 48 * k;  my[s][k] = 20 + 36 * k;
                mvx[s][k] = 0;           mvy[s][k] = 0;
            end
            busy_until[s] = -1;
        end
    endfunction

    function automatic void move(input int p0, input int v0, input int size,
                                 input int b, output int p1, output int v1);
        p1 = p0 + v0;
        v1 = v0;
        if (b != 0) begin
            if (p1 < 0)              begin p1 = 0;        v1 = -v0; end
            else if (p1 > size - 1)  begin p1 = size - 1; v1 = -v0; end
        end else begin
            if (p1 < 0)          p1 += size;
            else if (p1 >= size) p1 -= size;
        end
    endfunction

    function automatic void model_frame(input int s);
        int ax[6], ay[6];
        int n, vmax, dx, dy, d, m, p, v;
        n = n_b[s];
        vmax = (1 << (vw_b[s] - 1)) - 1;
        for (int k = 0; k < 6; k++) begin ax[k] = 0; ay[k] = 0; end
        for (int i = 0; i < n; i++) begin
            for (int j = i + 1; j < n; j++) begin
                dx = mx[s][j] - mx[s][i];
                dy = my[s][j] - my[s][i];
                d  = iabs(dx) + iabs(dy);
                m  = (d < 20) ? 2 : ((d < 120) ? 1 : 0);
                ax[i] += (dx < 0) ? -m : m;  ax[j] -= (dx < 0) ? -m : m;
                ay[i] += (dy < 0) ? -m : m;  ay[j] -= (dy < 0) ? -m : m;
            end
        end
        for (int k = 0; k < n; k++) begin
            v = mvx[s][k] + ax[k];
            v = (v > vmax) ? vmax : ((v < -vmax) ? -vmax : v);
            move(mx[s][k], v, 320, bnc[s], p, v);
            mx[s][k] = p;  mvx[s][k] = v;
            v = mvy[s][k] + ay[k];
            v = (v > vmax) ? vmax : ((v < -vmax) ? -vmax : v);
            move(my[s][k], v, 240, bnc[s], p, v);
            my[s][k] = p;  mvy[s][k] = v;
        end
    endfunction

    function automatic int model_hit(input int s, input int x, input int y);
        for (int b = 0; b < n_b[s]; b++)
            if (iabs(x - mx[s][b]) <= 8 && iabs(y - my[s][b]) <= 8) return b;
        return 7;
    endfunction

    task automatic read_body(input int s, input int k, output int x, output int y,
                             output int vx, output int vy);
        if (s == 0) begin
            x = int'(dut_a.r_x[k]);   y = int'(dut_a.r_y[k]);
            vx = int'(dut_a.r_vx[k]); vy = int'(dut_a.r_vy[k]);
        end else begin
            x = int'(dut_b.r_x[k]);   y = int'(dut_b.r_y[k]);
            vx = int'(dut_b.r_vx[k]); vy = int'(dut_b.r_vy[k]);
        end
    endtask

    task automatic check_state(input int s, input string tag);
        int x, y, vx, vy;
        for (int k = 0; k < n_b[s]; k++) begin
            read_body(s, k, x, y, vx, vy);
            check_val($sformatf("%s%0d_x%0d", tag, s, k), x, mx[s][k]);
            check_val($sformatf("%s%0d_y%0d", tag, s, k), y, my[s][k]);
            check_val($sformatf("%s%0d_vx%0d", tag, s, k), vx, mvx[s][k]);
            check_val($sformatf("%s%0d_vy%0d", tag, s, k), vy, mvy[s][k]);
            if (vw_b[s] == 4)
                check_val($sformatf("%s%0d_vbound%0d", tag, s, k),
                          int'(iabs(vx) <= 7 && iabs(vy) <= 7), 1);
        end
    endtask

    // One clock: model samples the same inputs the DUTs sample, checks on the falling edge.
    task automatic step();
        @(posedge clk);
        edge_cnt++;
        for (int s = 0; s < 2; s++) begin
            if (rst_n && tick && !pause && edge_cnt > busy_until[s]) begin
                model_frame(s);
                busy_until[s] = edge_cnt + n_b[s] * (n_b[s] - 1) / 2 + n_b[s];
            end
        end
        @(negedge clk);
        check_val("busy_a", int'(bus_a.busy), int'(edge_cnt < busy_until[0]));
        check_val("busy_b", int'(bus_b.busy), int'(edge_cnt < busy_until[1]));
        for (int s = 0; s < 2; s++)
            if (edge_cnt == busy_until[s]) check_state(s, "frame");
    endtask

    task automatic probe();
        int tx, ty, b, s0, eh, got_rgb, got_hit;
        for (int r = 0; r < 2; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                s0 = int'($urandom_range(0, 1));
                b  = int'($urandom_range(0, n_b[s0] - 1));
                tx = mx[s0][b] + int'($urandom_range(0, 20)) - 10;
                ty = my[s0][b] + int'($urandom_range(0, 20)) - 10;
                tx = (tx < 0) ? 0 : ((tx > 319) ? 319 : tx);
                ty = (ty < 0) ? 0 : ((ty > 239) ? 239 : ty);
            end else begin
                tx = int'($urandom_range(0, 319));
                ty = int'($urandom_range(0, 239));
            end
            va = ($urandom_range(0, 7) != 0);
            px = 9'(tx);
            py = 8'(ty);
            #1;
            for (int s = 0; s < 2; s++) begin
                if (edge_cnt >= busy_until[s]) begin
                    eh      = model_hit(s, tx, ty);
                    got_rgb = (s == 0) ? int'(bus_a.rgb) : int'(bus_b.rgb);
                    got_hit = (s == 0) ? int'(bus_a.hit_id) : int'(bus_b.hit_id);
                    check_val($sformatf("rgb%0d", s), got_rgb, (va && eh != 7) ? pal[eh] : 0);
                    if (va) check_val($sformatf("hit%0d", s), got_hit, eh);
                end
            end
        end
    endtask

    task automatic run_random(input int cycles);
        repeat (cycles) begin
            step();
            probe();
            tick  = ($urandom_range(0, 3) == 0);
            pause = ($urandom_range(0, 4) == 0);
        end
        tick  = 1'b0;
        pause = 1'b0;
    endtask

    // Reset-state pixel table: {x, y, rgb, hit_id}
    int pt[11][4] = '{
        '{16, 12, 57, 0}, '{32, 28, 57, 0}, '{16, 28, 57, 0}, '{32, 12, 57, 0},
        '{0, 0, 0, 7},    '{15, 20, 0, 7},  '{33, 20, 0, 7},  '{24, 11, 0, 7},
        '{24, 29, 0, 7},  '{72, 56, 46, 1}, '{120, 92, 23, 2}
    };
    int exp1[3][4] = '{'{25, 21, 1, 1}, '{72, 56, 0, 0}, '{119, 91, -1, -1}};

    initial begin
        int n_busy, x, y, vx, vy;
        errors = 0; checks = 0; edge_cnt = 0;
        tick = 1'b0; pause = 1'b0; va = 1'b1; px = '0; py = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_busy", int'(bus_a.busy), 0);
        check_state(0, "rst");
        check_state(1, "rst");
        for (int i = 0; i < 11; i++) begin
            px = 9'(pt[i][0]);
            py = 8'(pt[i][1]);
            #1;
            check_val("rst_rgb", int'(bus_a.rgb), pt[i][2]);
            check_val("rst_hit", int'(bus_a.hit_id), pt[i][3]);
        end
        va = 1'b0; px = 9'd24; py = 8'd20;
        #1;
        check_val("blank_rgb", int'(bus_a.rgb), 0);
        va = 1'b1;

        // Single frame: busy length and known first-frame state
        @(negedge clk);
        tick = 1'b1;
        step();
        tick = 1'b0;
        n_busy = int'(bus_a.busy);
        repeat (15) begin step(); n_busy += int'(bus_a.busy); end
        check_val("busy_len", n_busy, 6);
        for (int k = 0; k < 3; k++) begin
            read_body(0, k, x, y, vx, vy);
            check_val("f1_x", x, exp1[k][0]);
            check_val("f1_y", y, exp1[k][1]);
            check_val("f1_vx", vx, exp1[k][2]);
            check_val("f1_vy", vy, exp1[k][3]);
        end

        // Re-trigger while busy, then a paused tick
        tick = 1'b1; step(); tick = 1'b0;
        n_busy = int'(bus_a.busy);
        step(); n_busy += int'(bus_a.busy);
        tick = 1'b1; step(); tick = 1'b0; n_busy += int'(bus_a.busy);
        repeat (13) begin step(); n_busy += int'(bus_a.busy); end
        check_val("busy_retrig", n_busy, 6);
        tick = 1'b1; pause = 1'b1; step(); tick = 1'b0; pause = 1'b0;
        n_busy = int'(bus_a.busy);
        repeat (11) begin step(); n_busy += int'(bus_a.busy); end
        check_val("busy_pause", n_busy, 0);
        check_state(0, "pause");
        check_state(1, "pause");

        run_random(2500);

        // Reset asserted during the third pair cycle
        repeat (12) step();
        tick = 1'b1; step(); tick = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("midrst_busy_a", int'(bus_a.busy), 0);
        check_val("midrst_busy_b", int'(bus_b.busy), 0);
        check_state(0, "midrst");
        check_state(1, "midrst");
        step();
        rst_n = 1'b1;

        run_random(600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
